hit_edge_detector: RTL and testbench

Per-frame collision classifier that feeds the smiley movement controller its `collision` pulse and 4-bit `HitEdgeCode`. It watches the VGA pixel stream during a frame, records every pixel where the smiley and a brick draw simultaneously, and classifies each such pixel by which side of the 64x64 smiley box it lies on. At the next `startOfFrame` it freezes the accumulated code. After a fixed delay it issues one `collision` pulse, timed to land while the movement controller sits in its move state.

---
 rtl/hit_edge_detector.sv | 156 +++++++++++++++
 tb/tb_hit_edge_detector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_edge_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hit_edge_detector: per-frame smiley/brick collision edge classifier.      |
// | Optional hit-pixel counter and report threshold: define HIT_COUNT_EN.     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module hit_edge_detector #(
  parameter int OBJECT_WIDTH_X = 64,
  parameter int OBJECT_HIGHT_Y = 64,
  parameter int EDGE_MARGIN    = 8,
  parameter int REPORT_DELAY   = 4,
  parameter int MIN_HIT_PIXELS = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic signed [10:0] smileyTopLeftX,
  input  logic signed [10:0] smileyTopLeftY,
  input  logic               smileyDrawingRequest,
  input  logic               brickDrawingRequest,
  output logic               collision,
  output logic [3:0]         HitEdgeCode,
  output logic [7:0]         collisionPixels
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_COUNTDOWN = 2'd2,
    ST_REPORT    = 2'd3
  } state_t;

  localparam logic [10:0] c_width    = 11'(OBJECT_WIDTH_X);
  localparam logic [10:0] c_height   = 11'(OBJECT_HIGHT_Y);
  localparam logic [10:0] c_margin   = 11'(EDGE_MARGIN);
  localparam logic [10:0] c_right    = 11'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic [10:0] c_bottom   = 11'(OBJECT_HIGHT_Y - EDGE_MARGIN);
  localparam logic [3:0]  c_delay_m1 = 4'(REPORT_DELAY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  acc_code_q, acc_code_d;
  logic [3:0]  code_q, code_d;
  logic        collision_q, collision_d;
  logic [7:0]  acc_count_q, acc_count_d;
  logic [7:0]  pixels_q, pixels_d;

  logic signed [11:0] off_x, off_y;
  logic               pix_hit;
  logic [3:0]         pix_code;
  logic               report_ok;

  always_comb begin
    off_x    = $signed({1'b0, pixelX}) - $signed({smileyTopLeftX[10], smileyTopLeftX});
    off_y    = $signed({1'b0, pixelY}) - $signed({smileyTopLeftY[10], smileyTopLeftY});
    pix_hit  = smileyDrawingRequest & brickDrawingRequest
             & ~off_x[11] & ~off_y[11]
             & (off_x[10:0] < c_width) & (off_y[10:0] < c_height);
    pix_code = 4'b0000;
    if (pix_hit) begin
      pix_code[3] = off_x[10:0] <  c_margin;
      pix_code[2] = off_y[10:0] <  c_margin;
      pix_code[1] = off_x[10:0] >= c_right;
      pix_code[0] = off_y[10:0] >= c_bottom;
    end
  end

`ifdef HIT_COUNT_EN
  logic [7:0] count_inc;
  always_comb begin
    count_inc = (acc_count_q == 8'hFF) ? acc_count_q : acc_count_q + 8'd1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_code_d = acc_code_q | pix_code;
    code_d     = code_q;
    pixels_d   = pixels_q;
`ifdef HIT_COUNT_EN
    acc_count_d = pix_hit ? count_inc : acc_count_q;
`else
    acc_count_d = 8'd0;
`endif

    if (state_q == ST_IDLE) begin
      acc_code_d  = 4'b0000;
      acc_count_d = 8'd0;
      if (startOfFrame) begin
        // The coincident pixel opens the first full frame.
        state_d     = ST_COLLECT;
        acc_code_d  = pix_code;
`ifdef HIT_COUNT_EN
        acc_count_d = {7'd0, pix_hit};
`endif
      end
    end else if (startOfFrame) begin
      // Snapshot; any pending report is superseded by this new one.
      code_d      = acc_code_q;
      pixels_d    = acc_count_q;
      acc_code_d  = pix_code;
`ifdef HIT_COUNT_EN
      acc_count_d = {7'd0, pix_hit};
`endif
      cnt_d       = c_delay_m1;
      state_d     = (REPORT_DELAY == 1) ? ST_REPORT : ST_COUNTDOWN;
    end else begin
      case (state_q)
        ST_COUNTDOWN: begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_REPORT;
          end
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
        ST_REPORT: state_d = ST_COLLECT;
        default:   state_d = state_q;
      endcase
    end

`ifdef HIT_COUNT_EN
    report_ok = (code_d != 4'b0000) && (pixels_d >= 8'(MIN_HIT_PIXELS));
`else
    report_ok = (code_d != 4'b0000);
`endif
    collision_d = (state_d == ST_REPORT) && report_ok;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      acc_code_q  <= 4'b0000;
      acc_count_q <= 8'd0;
      code_q      <= 4'b0000;
      pixels_q    <= 8'd0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_code_q  <= acc_code_d;
      acc_count_q <= acc_count_d;
      code_q      <= code_d;
      pixels_q    <= pixels_d;
      collision_q <= collision_d;
    end
  end

  assign collision       = collision_q;
  assign HitEdgeCode     = code_q;
  assign collisionPixels = pixels_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_edge_detector.sv
`default_nettype none
// Bench for hit_edge_detector: frame-level reference model, directed scenarios, random traffic.
module tb_hit_edge_detector;

  localparam int W   = 64;
  localparam int H   = 64;
  localparam int M   = 8;
  localparam int D   = 4;
  localparam int MIN = 4;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic [10:0]        pixelX = '0;
  logic [10:0]        pixelY = '0;
  logic signed [10:0] smileyTopLeftX = '0;
  logic signed [10:0] smileyTopLeftY = '0;
  logic               smileyDrawingRequest = 1'b0;
  logic               brickDrawingRequest = 1'b0;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic [7:0]         collisionPixels;

  hit_edge_detector #(
    .OBJECT_WIDTH_X(W), .OBJECT_HIGHT_Y(H), .EDGE_MARGIN(M),
    .REPORT_DELAY(D), .MIN_HIT_PIXELS(MIN)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .smileyTopLeftX(smileyTopLeftX), .smileyTopLeftY(smileyTopLeftY),
    .smileyDrawingRequest(smileyDrawingRequest), .brickDrawingRequest(brickDrawingRequest),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .collisionPixels(collisionPixels)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_count = 0;
  bit checking = 1'b0;

  // Reference: frames delimited by startOfFrame; a report is scheduled D-1 edges after a snapshot.
  bit       m_in_frame = 1'b0;
  bit [3:0] m_acc = '0;
  int       m_cnt = 0;
  bit [3:0] exp_code = '0;
  int       exp_pix = 0;
  int       pulse_at = -1;
  int       edge_no = 0;
  bit       exp_coll = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [3:0] classify(input int px, input int py, input int tx, input int ty,
                                        input bit sm, input bit br, output bit valid);
    int ox, oy;
    bit [3:0] c;
    ox = px - tx;
    oy = py - ty;
    valid = sm && br && ox >= 0 && ox < W && oy >= 0 && oy < H;
    c = '0;
    if (valid) begin
      c[3] = ox < M;
      c[2] = oy < M;
      c[1] = ox >= W - M;
      c[0] = oy >= H - M;
    end
    return c;
  endfunction

  task automatic model_step();
    bit v;
    bit [3:0] pc;
    bit ok;
    edge_no++;
    if (!resetN) begin
      m_in_frame = 1'b0; m_acc = '0; m_cnt = 0;
      exp_code = '0; exp_pix = 0; pulse_at = -1; exp_coll = 1'b0;
      return;
    end
    pc = classify(int'(pixelX), int'(pixelY), int'(smileyTopLeftX), int'(smileyTopLeftY),
                  smileyDrawingRequest, brickDrawingRequest, v);
    if (startOfFrame) begin
      if (m_in_frame) begin
        exp_code = m_acc;
        exp_pix  = m_cnt;
        pulse_at = edge_no + D - 1;
      end
      m_in_frame = 1'b1;
      m_acc = pc;
      m_cnt = v ? 1 : 0;
    end else if (m_in_frame) begin
      m_acc = m_acc | pc;
      if (v && m_cnt < 255) m_cnt++;
    end
`ifdef HIT_COUNT_EN
    ok = exp_pix >= MIN;
`else
    ok = 1'b1;
`endif
    exp_coll = (pulse_at == edge_no) && (exp_code != 0) && ok;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("collision", int'(collision), int'(exp_coll));
      chk("HitEdgeCode", int'(HitEdgeCode), int'(exp_code));
`ifdef HIT_COUNT_EN
      chk("collisionPixels", int'(collisionPixels), exp_pix);
`else
      chk("collisionPixels", int'(collisionPixels), 0);
`endif
      if (collision === 1'b1) pulse_count++;
    end
  end

  task automatic step(input bit rn, input bit sof, input int px, input int py, input bit sm, input bit br);
    resetN = rn; startOfFrame = sof;
    pixelX = 11'(px); pixelY = 11'(py);
    smileyDrawingRequest = sm; brickDrawingRequest = br;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic hits(input int n, input int px, input int py);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, px, py, 1'b1, 1'b1);
  endtask

  int p0;
  int gap;
  int tx, ty;

  initial begin
    smileyTopLeftX = 11'sd100;
    smileyTopLeftY = 11'sd100;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    checking = 1'b1;
    chk("reset_collision", int'(collision), 0);
    chk("reset_code", int'(HitEdgeCode), 0);
    chk("reset_pixels", int'(collisionPixels), 0);

    // Partial frame after reset is discarded.
    p0 = pulse_count;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 100, 130, 1'b1, 1'b1);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("partial_code", int'(HitEdgeCode), 0);
    chk("partial_pulses", pulse_count - p0, 0);

    // Five left-edge hits, pulse exactly D cycles after the frame start.
    hits(5, 100, 130);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("left_code", int'(HitEdgeCode), 8);
`ifdef HIT_COUNT_EN
    chk("left_pixels", int'(collisionPixels), 5);
`endif
    chk("left_t1", int'(collision), 0);
    idle(1); chk("left_t2", int'(collision), 0);
    idle(1); chk("left_t3", int'(collision), 0);
    idle(1); chk("left_t4", int'(collision), 1);
    idle(1); chk("left_t5", int'(collision), 0);

    p0 = pulse_count;
    hits(2, 163, 163);
    hits(2, 130, 100);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("rbt_code", int'(HitEdgeCode), 7);
    chk("rbt_pulses", pulse_count - p0, 1);

    p0 = pulse_count;
    hits(4, 132, 132);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("interior_code", int'(HitEdgeCode), 0);
    chk("interior_pulses", pulse_count - p0, 0);

    p0 = pulse_count;
    hits(3, 100, 110);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("three_code", int'(HitEdgeCode), 8);
`ifdef HIT_COUNT_EN
    chk("three_pulses", pulse_count - p0, 0);
`else
    chk("three_pulses", pulse_count - p0, 1);
`endif
    p0 = pulse_count;
    hits(4, 100, 110);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("four_pulses", pulse_count - p0, 1);

    // Reset in the middle of the countdown cancels the report.
    p0 = pulse_count;
    hits(5, 100, 110);
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("rst_cd_collision", int'(collision), 0);
    chk("rst_cd_code", int'(HitEdgeCode), 0);
    chk("rst_cd_pixels", int'(collisionPixels), 0);
    idle(6);
    chk("rst_cd_pulses", pulse_count - p0, 0);

    // A hit coincident with startOfFrame belongs to the following frame.
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(3);
    p0 = pulse_count;
    step(1'b1, 1'b1, 100, 120, 1'b1, 1'b1);
    idle(6);
    chk("coinc_first_code", int'(HitEdgeCode), 0);
    chk("coinc_first_pulses", pulse_count - p0, 0);
    p0 = pulse_count;
    step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("coinc_next_code", int'(HitEdgeCode), 8);
`ifdef HIT_COUNT_EN
    chk("coinc_next_pulses", pulse_count - p0, 0);
`else
    chk("coinc_next_pulses", pulse_count - p0, 1);
`endif

    // Random traffic around a moving smiley, with short frames and occasional resets.
    gap = 10;
    for (int i = 0; i < 5000; i++) begin
      bit sof, rn;
      rn = ($urandom_range(0, 299) != 0);
      sof = 1'b0;
      if (gap == 0) begin
        sof = 1'b1;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(5, 40);
        tx = $urandom_range(10, 900);
        ty = $urandom_range(10, 900);
      end else begin
        gap--;
      end
      if (i == 0) begin
        tx = 200; ty = 200;
      end
      smileyTopLeftX = 11'(tx);
      smileyTopLeftY = 11'(ty);
      step(rn, sof, tx + $urandom_range(0, 79) - 8, ty + $urandom_range(0, 79) - 8,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
